// File: rtl/dip_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dip_seq_pkg
//  Description : Shared state encoding and width helpers for the DiP tile
//                sequencer and its step counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package dip_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_ROWS = 16;

    // Width of a counter that must hold every value 0..max_value.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_MAX_ROWS);
    localparam int DEF_S_W   = cnt_width(DEF_MAX_ROWS + DEF_N);

endpackage
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_counter
//  Description : Clearable up-counter with terminal-value compare. The caller
//                gates inc; the counter itself never wraps on its own accord
//                because tiles clear it before every use.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] value,
    output logic             is_max
);

    // Count register: clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= value + WIDTH'(1);
        end
    end

    assign is_max = (value == max_val);

endmodule
`default_nettype wire

// File: rtl/dip_tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dip_tile_sequencer
//  Description : Tile control for the DiP systolic array. Loads N weight rows,
//                streams M input rows, flushes the pipeline and drains M
//                result rows, with an array-wide stall on result backpressure.
//                Optional macro DIP_SEQ_ABORT_EN adds an abort input that
//                returns a busy sequencer to IDLE without a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module dip_tile_sequencer
    import dip_seq_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_ROWS = DEF_MAX_ROWS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(MAX_ROWS+1)-1:0] cfg_rows,
    output logic                          busy,
    output logic                          done,
    output logic                          w_load_en,
    output logic [$clog2(N)-1:0]          w_row_idx,
    input  logic                          x_valid,
    output logic                          x_ready,
    output logic                          pe_en,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef DIP_SEQ_ABORT_EN
    input  logic                          abort,
`endif
    output logic [$clog2(MAX_ROWS)-1:0]   out_row_idx
);

    localparam int CNT_W = $clog2(MAX_ROWS + 1);
    localparam int S_W   = cnt_width(MAX_ROWS + N);
    localparam int W_W   = $clog2(N);
    localparam int IDX_W = $clog2(MAX_ROWS);

    seq_state_t       state;
    seq_state_t       next_state;

    logic [CNT_W-1:0] m_rows;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [S_W-1:0]   s_cnt;
    logic [S_W-1:0]   s_end;
    logic [W_W-1:0]   w_cnt;

    logic             start_ok;
    logic             in_tile;
    logic             abort_req;
    logic             cnt_clr;
    logic             active;
    logic             step_ok;
    logic             out_hs;
    logic             out_all;
    logic             s_at_end;
    logic             w_inc;
    logic             in_inc;
    logic             w_is_max;
    logic             in_is_max;
    logic             s_is_max;
    logic             out_is_max;

    assign start_ok = (state == IDLE) && start && (cfg_rows != '0);
    assign in_tile  = (state == LOAD_W) || (state == STREAM) ||
                      (state == FLUSH)  || (state == DRAIN);

`ifdef DIP_SEQ_ABORT_EN
    assign abort_req = abort && in_tile;
`else
    assign abort_req = 1'b0;
`endif

    // The last step of a tile leaves s at M+N-1: the step exposing row M-1.
    assign s_end    = S_W'(m_rows) + S_W'(N - 1);
    assign s_at_end = (s_cnt == s_end);

    // Row r sits at the array edge exactly when s == r+N; the equality keeps
    // the row stable while the whole array is stalled on out_ready.
    assign active    = (state == STREAM) || (state == FLUSH) || (state == DRAIN);
    assign out_valid = active && (s_cnt == S_W'(out_cnt) + S_W'(N)) && (out_cnt < m_rows);
    assign step_ok   = !out_valid || out_ready;
    assign out_hs    = out_valid && out_ready;
    assign out_all   = (out_cnt == m_rows);

    assign w_row_idx   = w_cnt;
    assign out_row_idx = out_cnt[IDX_W-1:0];

    assign w_inc  = (state == LOAD_W) && !w_is_max;
    assign in_inc = (state == STREAM) && pe_en;

    seq_counter #(.WIDTH(W_W)) u_w_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (w_inc),
        .max_val (W_W'(N - 1)),
        .value   (w_cnt),
        .is_max  (w_is_max)
    );

    seq_counter #(.WIDTH(CNT_W)) u_in_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (in_inc),
        .max_val (m_rows - CNT_W'(1)),
        .value   (in_cnt),
        .is_max  (in_is_max)
    );

    seq_counter #(.WIDTH(S_W)) u_s_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (pe_en),
        .max_val (s_end - S_W'(1)),
        .value   (s_cnt),
        .is_max  (s_is_max)
    );

    seq_counter #(.WIDTH(CNT_W)) u_out_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (out_hs),
        .max_val (m_rows - CNT_W'(1)),
        .value   (out_cnt),
        .is_max  (out_is_max)
    );

    // Tile row count captured when a tile is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rows <= '0;
        end else if (start_ok) begin
            m_rows <= cfg_rows;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        w_load_en  = 1'b0;
        x_ready    = 1'b0;
        pe_en      = 1'b0;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    cnt_clr    = 1'b1;
                    next_state = LOAD_W;
                end
            end
            LOAD_W: begin
                busy      = 1'b1;
                w_load_en = 1'b1;
                if (w_is_max) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                busy    = 1'b1;
                x_ready = step_ok && (in_cnt < m_rows);
                pe_en   = x_valid && x_ready;
                if (pe_en && in_is_max) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                busy  = 1'b1;
                pe_en = step_ok && !s_at_end;
                if (s_at_end || (pe_en && s_is_max)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_all || (out_hs && out_is_max)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (abort_req) begin
            cnt_clr    = 1'b1;
            next_state = IDLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dip_tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dip_tile_sequencer
//  Description : Directed self-checking bench for dip_tile_sequencer (N=4,
//                MAX_ROWS=16). Define DIP_SEQ_ABORT_EN to exercise abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dip_tile_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] cfg_rows;
    logic       busy;
    logic       done;
    logic       w_load_en;
    logic [1:0] w_row_idx;
    logic       x_valid;
    logic       x_ready;
    logic       pe_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_row_idx;
`ifdef DIP_SEQ_ABORT_EN
    logic       abort;
`endif

    int checks = 0;
    int errors = 0;

    int n_load, load_sig, n_pe, n_pe_str, n_xhs, n_out, row_sig;
    int bad_step, bad_pe, n_done, bad_done;

    dip_tile_sequencer #(.N(4), .MAX_ROWS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_rows    (cfg_rows),
        .busy        (busy),
        .done        (done),
        .w_load_en   (w_load_en),
        .w_row_idx   (w_row_idx),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .pe_en       (pe_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef DIP_SEQ_ABORT_EN
        .abort       (abort),
`endif
        .out_row_idx (out_row_idx)
    );

    always #5 clk = ~clk;

    task automatic clear_mon();
        n_load = 0; load_sig = 0; n_pe = 0; n_pe_str = 0; n_xhs = 0;
        n_out = 0; row_sig = 0; bad_step = 0; bad_pe = 0; n_done = 0; bad_done = 0;
    endtask

    // Record one cycle of activity; row r must leave after exactly r+N steps.
    task automatic sample();
        if (w_load_en) begin
            load_sig = (load_sig << 2) | int'(w_row_idx);
            n_load++;
        end
        if (out_valid && out_ready) begin
            if (n_pe != int'(out_row_idx) + N) bad_step++;
            row_sig = (row_sig << 4) | int'(out_row_idx);
            n_out++;
        end
        if (pe_en) begin
            n_pe++;
            if (x_ready) n_pe_str++;
        end
        if (x_valid && x_ready) n_xhs++;
        if (pe_en && ((x_ready && !x_valid) || (out_valid && !out_ready))) bad_pe++;
        if (done) begin
            n_done++;
            if (busy) bad_done++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    // mode 0: steady; mode 1: x_valid every other cycle; mode 2: start held in STREAM.
    task automatic run_tile(input int m, input int mode, input int budget);
        clear_mon();
        start     = 1'b1;
        cfg_rows  = 5'(m);
        x_valid   = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < budget && n_done == 0; c++) begin
            if (mode == 1) x_valid = (c % 2 == 1);
            if (mode == 2) begin
                start    = x_ready;
                cfg_rows = 5'd5;
            end
            step();
        end
        start   = 1'b0;
        x_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_rows = '0; x_valid = 1'b0; out_ready = 1'b0;
`ifdef DIP_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        step();
        step();
        checks++;
        if ({busy, done, w_load_en, w_row_idx, x_ready, pe_en, out_valid, out_row_idx} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {busy, done, w_load_en, w_row_idx, x_ready, pe_en, out_valid, out_row_idx});
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || w_load_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b w_load_en=%b required 0 0", busy, w_load_en);
        end
    endtask

    task automatic test_reset_mid_stream();
        clear_mon();
        start = 1'b1; cfg_rows = 5'd3; x_valid = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (busy !== 1'b1 || x_ready !== 1'b1 || pe_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_stream_pre: busy=%b x_ready=%b pe_en=%b required 1 1 1", busy, x_ready, pe_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, w_load_en, w_row_idx, x_ready, pe_en, out_valid, out_row_idx} !== 13'd0) begin
            errors++;
            $display("FAIL mid_stream_rst_outputs: got %b required 0", {busy, done, w_load_en, w_row_idx, x_ready, pe_en, out_valid, out_row_idx});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || w_load_en !== 1'b0 || x_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_stream_after_release: busy=%b w_load_en=%b x_ready=%b required 0 0 0", busy, w_load_en, x_ready);
        end
        x_valid = 1'b0;
    endtask

    task automatic test_basic_tile();
        run_tile(3, 0, 40);
        checks++;
        if (n_done != 1 || bad_done != 0) begin
            errors++;
            $display("FAIL basic_done: pulses=%0d busy_during_done=%0d required 1 0", n_done, bad_done);
        end
        checks++;
        if (n_load != 4 || load_sig != 'h1B) begin
            errors++;
            $display("FAIL basic_weight_load: count=%0d idx_seq=%h required 4 1b", n_load, load_sig);
        end
        checks++;
        if (n_xhs != 3 || n_pe != 6) begin
            errors++;
            $display("FAIL basic_steps: x_hs=%0d pe=%0d required 3 6", n_xhs, n_pe);
        end
        checks++;
        if (n_out != 3 || row_sig != 'h012 || bad_step != 0) begin
            errors++;
            $display("FAIL basic_rows: count=%0d seq=%h bad_step=%0d required 3 012 0", n_out, row_sig, bad_step);
        end
        checks++;
        if (busy !== 1'b0 || bad_pe != 0) begin
            errors++;
            $display("FAIL basic_end_state: busy=%b bad_pe=%0d required 0 0", busy, bad_pe);
        end
    endtask

    task automatic test_sparse_input();
        run_tile(2, 1, 40);
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL sparse_done: pulses=%0d required 1", n_done);
        end
        checks++;
        if (n_pe_str != 2 || n_xhs != 2 || bad_pe != 0) begin
            errors++;
            $display("FAIL sparse_stream_steps: pe_in_stream=%0d x_hs=%0d bad_pe=%0d required 2 2 0", n_pe_str, n_xhs, bad_pe);
        end
        checks++;
        if (n_pe != 5) begin
            errors++;
            $display("FAIL sparse_total_steps: pe=%0d required 5", n_pe);
        end
        checks++;
        if (n_out != 2 || row_sig != 'h01 || bad_step != 0) begin
            errors++;
            $display("FAIL sparse_rows: count=%0d seq=%h bad_step=%0d required 2 01 0", n_out, row_sig, bad_step);
        end
    endtask

    task automatic test_backpressure();
        int  stall_left;
        int  stall_seen;
        logic stalling;
        clear_mon();
        stall_left = 5;
        stall_seen = 0;
        start = 1'b1; cfg_rows = 5'd4; x_valid = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 60 && n_done == 0; c++) begin
            stalling  = (out_valid === 1'b1) && (out_row_idx == 4'd1) && (stall_left > 0);
            out_ready = !stalling;
            @(negedge clk);
            if (stalling) begin
                checks++;
                if (out_valid !== 1'b1 || out_row_idx !== 4'd1 || pe_en !== 1'b0 || x_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b idx=%0d pe_en=%b x_ready=%b required 1 1 0 0", out_valid, out_row_idx, pe_en, x_ready);
                end
                stall_left--;
                stall_seen++;
            end
            sample();
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        x_valid   = 1'b0;
        checks++;
        if (stall_seen != 5 || n_done != 1) begin
            errors++;
            $display("FAIL stall_window: stall_cycles=%0d done=%0d required 5 1", stall_seen, n_done);
        end
        checks++;
        if (n_out != 4 || row_sig != 'h0123 || bad_step != 0) begin
            errors++;
            $display("FAIL stall_rows: count=%0d seq=%h bad_step=%0d required 4 0123 0", n_out, row_sig, bad_step);
        end
        checks++;
        if (n_pe != 7 || bad_pe != 0) begin
            errors++;
            $display("FAIL stall_steps: pe=%0d bad_pe=%0d required 7 0", n_pe, bad_pe);
        end
    endtask

    task automatic test_ignored_start();
        clear_mon();
        start = 1'b1; cfg_rows = 5'd0; x_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || n_load != 0 || n_done != 0) begin
            errors++;
            $display("FAIL zero_rows_start: busy=%b loads=%0d done=%0d required 0 0 0", busy, n_load, n_done);
        end
        run_tile(2, 2, 40);
        checks++;
        if (n_done != 1 || n_load != 4 || n_pe != 5) begin
            errors++;
            $display("FAIL start_in_stream_tile: done=%0d loads=%0d pe=%0d required 1 4 5", n_done, n_load, n_pe);
        end
        checks++;
        if (n_out != 2 || row_sig != 'h01) begin
            errors++;
            $display("FAIL start_in_stream_rows: count=%0d seq=%h required 2 01", n_out, row_sig);
        end
        clear_mon();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (busy !== 1'b0 || n_load != 0) begin
            errors++;
            $display("FAIL start_in_stream_no_relaunch: busy=%b loads=%0d required 0 0", busy, n_load);
        end
    endtask

`ifdef DIP_SEQ_ABORT_EN
    task automatic test_abort();
        bit found;
        found = 1'b0;
        clear_mon();
        start = 1'b1; cfg_rows = 5'd3; x_valid = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (busy && pe_en && !x_ready) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_flush: flush seen=%0d required 1", found);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pe_en !== 1'b0 || w_load_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_to_idle: busy=%b done=%b pe_en=%b w_load_en=%b required 0 0 0 0", busy, done, pe_en, w_load_en);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: pulses=%0d required 0", n_done);
        end
        run_tile(1, 0, 30);
        checks++;
        if (n_done != 1 || n_out != 1 || row_sig != 0 || n_pe != 4 || bad_step != 0) begin
            errors++;
            $display("FAIL abort_followup_tile: done=%0d rows=%0d seq=%h pe=%0d bad_step=%0d required 1 1 0 4 0", n_done, n_out, row_sig, n_pe, bad_step);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_stream();
        test_basic_tile();
        test_sparse_input();
        test_backpressure();
        test_ignored_start();
`ifdef DIP_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
